// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core datapath blocks.
package mips_pkg;

    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} muldiv_op_e;
    typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX} muldiv_state_e;

    localparam int MD_ITERS = 32;
    localparam int MD_CNT_W = $clog2(MD_ITERS);

    function automatic logic md_is_signed(input muldiv_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input muldiv_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mips_muldiv_iter.sv
// 64-bit accumulator with one radix-2 shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle on unsigned magnitudes.
module mips_muldiv_iter
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_is_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_next;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem;
    logic [WIDTH:0]     w_diff;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        w_sum  = '0;
        w_rem  = '0;
        w_diff = '0;
        w_next = r_acc;
        if (i_is_div) begin
            // Partial remainder shifted left with the next dividend bit; borrow means "does not fit".
            w_rem  = r_acc[2*WIDTH-1:WIDTH-1];
            w_diff = w_rem - {1'b0, i_b};
            if (!w_diff[WIDTH])
                w_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            else
                w_next = {w_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end else begin
            w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                     (r_acc[0] ? {1'b0, i_b} : {(WIDTH+1){1'b0}});
            w_next = {w_sum, r_acc[WIDTH-1:1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_acc <= '0;
        else if (i_load)
            r_acc <= {{WIDTH{1'b0}}, i_a};
        else if (i_step)
            r_acc <= w_next;
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Operands are reduced to magnitudes on launch; signs are reapplied in FIX.
module mips_muldiv_unit
    import mips_pkg::*;
#(
    parameter int             WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             MtHi,
    input  logic             MtLo,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    muldiv_state_e       r_state;
    logic [MD_CNT_W-1:0] r_cnt;
    logic                r_is_div;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_div0;
    logic [WIDTH-1:0]    r_raw_a;
    logic [WIDTH-1:0]    r_b_mag;

    muldiv_op_e          w_op;
    logic                w_signed;
    logic                w_load;
    logic [WIDTH-1:0]    w_a_mag;
    logic [WIDTH-1:0]    w_b_mag;
    logic [2*WIDTH-1:0]  w_acc;
    logic [2*WIDTH-1:0]  w_prod;
    logic [WIDTH-1:0]    w_q;
    logic [WIDTH-1:0]    w_r;
    logic [WIDTH-1:0]    w_hi_fix;
    logic [WIDTH-1:0]    w_lo_fix;

    assign w_op     = muldiv_op_e'(Op);
    assign w_signed = md_is_signed(w_op);
    assign w_load   = (r_state == MD_IDLE) && Start;
    // Unsigned magnitude: 0x8000_0000 negates to itself, which reads correctly as 2^31.
    assign w_a_mag  = (w_signed && OpA[WIDTH-1]) ? -OpA : OpA;
    assign w_b_mag  = (w_signed && OpB[WIDTH-1]) ? -OpB : OpB;

    mips_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .Clk      (Clk),
        .Reset    (Reset),
        .i_load   (w_load),
        .i_step   (r_state == MD_CALC),
        .i_is_div (w_load ? md_is_div(w_op) : r_is_div),
        .i_a      (w_a_mag),
        .i_b      (r_b_mag),
        .o_acc    (w_acc)
    );

    always_comb begin
        w_prod   = r_neg_q ? -w_acc : w_acc;
        w_q      = r_neg_q ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
        w_r      = r_neg_r ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];
        w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
        w_lo_fix = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            w_hi_fix = r_div0 ? r_raw_a : w_r;
            w_lo_fix = r_div0 ? DIV0_LO : w_q;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= MD_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_raw_a  <= '0;
            r_b_mag  <= '0;
            Hi       <= '0;
            Lo       <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    // MT writes land even when Start launches in the same cycle; FIX overwrites later.
                    if (MtHi) Hi <= OpA;
                    if (MtLo) Lo <= OpA;
                    if (Start) begin
                        r_state  <= MD_CALC;
                        r_cnt    <= MD_CNT_W'(MD_ITERS - 1);
                        r_is_div <= md_is_div(w_op);
                        r_neg_q  <= w_signed && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
                        r_neg_r  <= w_signed && md_is_div(w_op) && OpA[WIDTH-1];
                        r_div0   <= md_is_div(w_op) && (OpB == '0);
                        r_raw_a  <= OpA;
                        r_b_mag  <= w_b_mag;
                        Busy     <= 1'b1;
                    end
                end
                MD_CALC: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0)
                        r_state <= MD_FIX;
                end
                MD_FIX: begin
                    Hi      <= w_hi_fix;
                    Lo      <= w_lo_fix;
                    Busy    <= 1'b0;
                    Done    <= 1'b1;
                    r_state <= MD_IDLE;
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: stimulus queues expected HI/LO,
// a monitor pops and compares whenever Done pulses.
module tb_mips_muldiv_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic        MtHi;
    logic        MtLo;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    mips_muldiv_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Op    (Op),
        .OpA   (OpA),
        .OpB   (OpB),
        .MtHi  (MtHi),
        .MtLo  (MtLo),
        .Hi    (Hi),
        .Lo    (Lo),
        .Busy  (Busy),
        .Done  (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every Done pulse must match the oldest queued expectation.
    always @(negedge Clk) begin
        if (!Reset && Done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: Done=1 with no pending op, expected Done=0");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_hi"}, {32'd0, Hi}, {32'd0, e.hi});
                check({e.name, "_lo"}, {32'd0, Lo}, {32'd0, e.lo});
            end
        end
    end

    // Called just after a rising edge; returns just after edge 0 of the op.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input logic [31:0] eh, input logic [31:0] el,
                          input string name);
        exp_t e;
        Op    = op;
        OpA   = a;
        OpB   = b;
        Start = 1'b1;
        if (push) begin
            e.hi = eh;
            e.lo = el;
            e.name = name;
            sb_q.push_back(e);
        end
        @(posedge Clk);
        #1;
        Start = 1'b0;
        MtHi  = 1'b0;
        MtLo  = 1'b0;
        check({name, "_busy_rise"}, {63'd0, Busy}, 64'd1);
    endtask

    // Counts edges after edge 0 until Done is seen; bounded so a stuck DUT still finishes.
    task automatic wait_done(input string name, input int n0);
        int n;
        for (n = n0 + 1; n <= 40; n++) begin
            @(posedge Clk);
            #1;
            if (Done) break;
        end
        check({name, "_latency"}, 64'(n), 64'd33);
        check({name, "_busy_fall"}, {63'd0, Busy}, 64'd0);
    endtask

    initial begin
        logic [31:0] hi_before;
        Reset = 1'b1;
        Start = 1'b0;
        Op    = 2'd0;
        OpA   = '0;
        OpB   = '0;
        MtHi  = 1'b0;
        MtLo  = 1'b0;
        #12;
        check("reset_hi",   {32'd0, Hi}, 64'd0);
        check("reset_lo",   {32'd0, Lo}, 64'd0);
        check("reset_busy", {63'd0, Busy}, 64'd0);
        check("reset_done", {63'd0, Done}, 64'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        launch(OP_MULT, 32'hFFFF_FFFF, 32'h2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult_neg");
        wait_done("mult_neg", 0);
        @(posedge Clk);
        #1;
        check("mult_done_pulse", {63'd0, Done}, 64'd0);

        launch(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 1, 32'h1, 32'hFFFF_FFFE, "multu");
        wait_done("multu", 0);

        launch(OP_DIV, 32'hFFFF_FFF9, 32'h2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        wait_done("div_m7_2", 0);

        launch(OP_DIV, 32'h7, 32'hFFFF_FFFE, 1, 32'h1, 32'hFFFF_FFFD, "div_7_m2");
        wait_done("div_7_m2", 0);

        launch(OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1, 32'h0, 32'hF, "mult_m3_m5");
        wait_done("mult_m3_m5", 0);

        launch(OP_DIVU, 32'h7, 32'h0, 1, 32'h7, 32'hFFFF_FFFF, "divu_by0");
        wait_done("divu_by0", 0);

        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 32'h8000_0000, "div_ovf");
        wait_done("div_ovf", 0);
        // Back-to-back: Start issued in the Done cycle.
        launch(OP_MULT, 32'h1234_5678, 32'h10, 1, 32'h1, 32'h2345_6780, "b2b_mult");
        wait_done("b2b_mult", 0);

        launch(OP_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, "divu_ign");
        hi_before = Hi;
        repeat (4) begin
            @(posedge Clk);
            #1;
        end
        Op    = OP_MULTU;
        OpA   = 32'hDEAD_BEEF;
        OpB   = 32'h3;
        Start = 1'b1;
        MtHi  = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        MtHi  = 1'b0;
        check("ign_hi_stable", {32'd0, Hi}, {32'd0, hi_before});
        check("ign_busy",      {63'd0, Busy}, 64'd1);
        wait_done("divu_ign", 5);

        MtHi = 1'b1;
        launch(OP_MULTU, 32'd6, 32'd7, 1, 32'd0, 32'd42, "mthi_start");
        check("mthi_with_start", {32'd0, Hi}, 64'd6);
        wait_done("mthi_start", 0);

        OpA  = 32'h0000_A5A5;
        MtHi = 1'b1;
        MtLo = 1'b1;
        @(posedge Clk);
        #1;
        MtHi = 1'b0;
        MtLo = 1'b0;
        check("mt_both_hi", {32'd0, Hi}, 64'h0000_A5A5);
        check("mt_both_lo", {32'd0, Lo}, 64'h0000_A5A5);

        launch(OP_MULT, 32'd3, 32'd5, 0, 32'd0, 32'd0, "mult_rst");
        repeat (9) begin
            @(posedge Clk);
            #1;
        end
        Reset = 1'b1;
        #1;
        check("midop_reset_busy", {63'd0, Busy}, 64'd0);
        check("midop_reset_hi",   {32'd0, Hi}, 64'd0);
        check("midop_reset_lo",   {32'd0, Lo}, 64'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        repeat (40) begin
            @(posedge Clk);
            #1;
        end
        check("post_reset_busy", {63'd0, Busy}, 64'd0);
        OpA  = 32'h0000_1234;
        MtLo = 1'b1;
        @(posedge Clk);
        #1;
        MtLo = 1'b0;
        check("mtlo_after_reset", {32'd0, Lo}, 64'h0000_1234);
        check("hi_after_reset",   {32'd0, Hi}, 64'd0);

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
